// File: rtl/serial_byte_rx.sv
// Serial-to-parallel receiver: shifts one bit per din_valid cycle into a DATA_W-bit word
// and holds each completed word in a valid/ready output register.
module serial_byte_rx #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      din,
  input  logic                      din_valid,
  input  logic                      clr,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [$clog2(DATA_W)-1:0] bit_cnt,
  output logic                      overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] word_c;
  logic              done_c;

  // Next shift value including the current bit, so a completing word needs no extra cycle.
  always_comb begin
    word_c = sr;
    if (MSB_FIRST) begin
      word_c = {sr[DATA_W-2:0], din};
    end else begin
      word_c = {din, sr[DATA_W-1:1]};
    end
    done_c = din_valid && !clr && (bit_cnt == LAST_BIT);
  end

  // Input shifter and bit counter; clr wins over an incoming bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (din_valid) begin
      sr      <= word_c;
      bit_cnt <= done_c ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  // Output holding register FSM with sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clr) begin
        overrun <= 1'b0;
      end
      case (state)
        EMPTY: begin
          if (done_c) begin
            dout       <= word_c;
            dout_valid <= 1'b1;
            state      <= FULL;
          end
        end
        FULL: begin
          if (done_c) begin
            if (dout_ready) begin
              dout <= word_c;
            end else begin
              overrun <= 1'b1;
            end
          end else if (dout_ready) begin
            dout_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
        default: begin
          state      <= EMPTY;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench for serial_byte_rx: one MSB-first and one LSB-first instance on shared inputs.
module tb_serial_byte_rx;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       clr;
  logic       dout_ready;
  logic [7:0] dout_m;
  logic [7:0] dout_l;
  logic       dv_m;
  logic       dv_l;
  logic [2:0] cnt_m;
  logic [2:0] cnt_l;
  logic       ovr_m;
  logic       ovr_l;

  int total = 0;
  int bad   = 0;

  serial_byte_rx #(.DATA_W(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr(clr),
    .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
    .bit_cnt(cnt_m), .overrun(ovr_m)
  );

  serial_byte_rx #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr(clr),
    .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
    .bit_cnt(cnt_l), .overrun(ovr_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send eight bits on consecutive cycles, v[7] first.
  task automatic send_bits(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      din       = v[i];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; clr = 1'b0; dout_ready = 1'b0;
    repeat (2) tick();
    chk("rst_dout", 32'(dout_m), 32'h0);
    chk("rst_dv", 32'(dv_m), 32'h0);
    chk("rst_cnt", 32'(cnt_m), 32'h0);
    chk("rst_ovr", 32'(ovr_m), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: MSB-first 1,0,1,1,0,1,0,0 -> 0xB4, valid for one cycle
    dout_ready = 1'b1;
    v = 8'hB4;
    for (int i = 7; i >= 1; i--) begin
      din = v[i]; din_valid = 1'b1; tick();
    end
    chk("t1_dv_before", 32'(dv_m), 32'h0);
    chk("t1_cnt7", 32'(cnt_m), 32'h7);
    din = v[0]; tick();
    din_valid = 1'b0;
    chk("t1_dv", 32'(dv_m), 32'h1);
    chk("t1_dout", 32'(dout_m), 32'hB4);
    chk("t1_cnt", 32'(cnt_m), 32'h0);
    tick();
    chk("t1_dv_after", 32'(dv_m), 32'h0);
    chk("t1_dout_hold", 32'(dout_m), 32'hB4);

    // 2: LSB-first same bits with a 3-cycle gap after bit 4 -> 0x2D
    for (int i = 7; i >= 4; i--) begin
      din = v[i]; din_valid = 1'b1; tick();
    end
    din_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("t2_gap_cnt", 32'(cnt_l), 32'h4);
    end
    for (int i = 3; i >= 0; i--) begin
      din = v[i]; din_valid = 1'b1; tick();
    end
    din_valid = 1'b0;
    chk("t2_dv", 32'(dv_l), 32'h1);
    chk("t2_dout_lsb", 32'(dout_l), 32'h2D);
    chk("t2_dout_msb", 32'(dout_m), 32'hB4);
    tick();

    // 3: back-to-back words with no ready -> overrun, first word kept
    dout_ready = 1'b0;
    send_bits(8'h11);
    chk("t3_dv", 32'(dv_m), 32'h1);
    chk("t3_dout1", 32'(dout_m), 32'h11);
    chk("t3_ovr0", 32'(ovr_m), 32'h0);
    send_bits(8'h22);
    chk("t3_dout_kept", 32'(dout_m), 32'h11);
    chk("t3_ovr1", 32'(ovr_m), 32'h1);
    tick();
    chk("t3_ovr_sticky", 32'(ovr_m), 32'h1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("t3_dv_drained", 32'(dv_m), 32'h0);
    chk("t3_dout_hold", 32'(dout_m), 32'h11);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3_ovr_clr", 32'(ovr_m), 32'h0);

    // 4: pending 0x33 accepted on the same edge 0x44 completes
    send_bits(8'h33);
    chk("t4_dout33", 32'(dout_m), 32'h33);
    v = 8'h44;
    for (int i = 7; i >= 1; i--) begin
      din = v[i]; din_valid = 1'b1; tick();
    end
    dout_ready = 1'b1; din = v[0]; tick();
    din_valid = 1'b0; dout_ready = 1'b0;
    chk("t4_dout44", 32'(dout_m), 32'h44);
    chk("t4_dv", 32'(dv_m), 32'h1);
    chk("t4_ovr", 32'(ovr_m), 32'h0);
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;
    chk("t4_dv_drained", 32'(dv_m), 32'h0);

    // 5: clr after 5 bits drops the coincident bit, pending word survives
    send_bits(8'h96);
    for (int i = 0; i < 5; i++) begin
      din = 1'b1; din_valid = 1'b1; tick();
    end
    chk("t5_cnt5", 32'(cnt_m), 32'h5);
    clr = 1'b1; din = 1'b1; din_valid = 1'b1; tick();
    clr = 1'b0; din_valid = 1'b0;
    chk("t5_cnt_clr", 32'(cnt_m), 32'h0);
    chk("t5_dv_kept", 32'(dv_m), 32'h1);
    chk("t5_dout_kept", 32'(dout_m), 32'h96);
    dout_ready = 1'b1; tick();
    chk("t5_dv_drained", 32'(dv_m), 32'h0);
    send_bits(8'hC3);
    chk("t5_doutC3", 32'(dout_m), 32'hC3);
    chk("t5_dvC3", 32'(dv_m), 32'h1);
    tick();

    // 6: asynchronous reset between edges with a pending word
    dout_ready = 1'b0;
    send_bits(8'hA5);
    for (int i = 0; i < 3; i++) begin
      din = 1'b1; din_valid = 1'b1; tick();
    end
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_dout", 32'(dout_m), 32'h0);
    chk("t6_rst_dv", 32'(dv_m), 32'h0);
    chk("t6_rst_cnt", 32'(cnt_m), 32'h0);
    chk("t6_rst_ovr", 32'(ovr_m), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    dout_ready = 1'b1;
    send_bits(8'h5A);
    chk("t6_dout5A", 32'(dout_m), 32'h5A);
    chk("t6_dv", 32'(dv_m), 32'h1);
    chk("t6_cnt", 32'(cnt_m), 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_byte_rx.md
Name: serial_byte_rx

Overview:
- Serial-to-parallel receiver. Collects a bit stream, one bit per qualified cycle, into DATA_W-bit words and presents each completed word on a valid/ready output.
- Bit order is set at build time, so the same block accepts MSB-first or LSB-first links. This makes it the deserialising counterpart of the team's bit-order/parallel datapath blocks.
- Sits between a serial link front-end and the byte-wide datapath.

Parameters:
- DATA_W, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = the first received bit becomes dout[DATA_W-1]; 0 = the first received bit becomes dout[0].

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled on this cycle's rising edge when high.
- clr  input  1  synchronous clear of the partial word and the overrun flag.
- dout  output  DATA_W  assembled word; stable while dout_valid=1.
- dout_valid  output  1  a word is pending.
- dout_ready  input  1  consumer accepts; transfer occurs when dout_valid & dout_ready.
- bit_cnt  output  clog2(DATA_W)  number of bits held in the partial word.
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:

Reset:
- rst_n=0 is asynchronous and immediate.
- It forces bit_cnt=0, the shift register to 0, dout=0, dout_valid=0 and overrun=0.
- Reset mid-word discards all partial bits. Reception restarts at bit 0 after release.

Shift register:
- Internal register sr, DATA_W bits.
- On each edge with din_valid=1 and clr=0:
  - MSB_FIRST=1: sr <= {sr[DATA_W-2:0], din}.
  - MSB_FIRST=0: sr <= {din, sr[DATA_W-1:1]}.
  - bit_cnt increments.
- din_valid=0 holds sr and bit_cnt. Gaps of any length between bits are legal.

Word completion:
- A word completes on the edge where din_valid=1 and bit_cnt=DATA_W-1.
- The assembled value includes the current bit, with no extra cycle.
- On that edge bit_cnt wraps to 0.
- Latency: dout_valid is high in the cycle after the edge that sampled the final bit.

Output register:
- Two states: EMPTY (dout_valid=0) and FULL (dout_valid=1).
- EMPTY + completion: dout <= word, go to FULL.
- FULL + dout_ready=1, no completion: go to EMPTY. dout holds its last value.
- FULL + dout_ready=1 + completion on the same edge: dout <= new word, stay FULL, no overrun.
- FULL + dout_ready=0 + completion: new word discarded, dout unchanged, overrun <= 1.
- dout and dout_valid must not change while dout_valid=1 and dout_ready=0. The only exception is reset.

clr:
- Sets bit_cnt=0, sr=0 and overrun=0.
- Has priority over din_valid on the same edge; that bit is discarded.
- Does not affect dout or dout_valid. A pending word survives clr.

overrun:
- Once set, it stays set until clr or reset. Further drops leave it at 1.

bit_cnt:
- Never reads DATA_W.
- Range is 0..DATA_W-1.

Test Plan:
1. MSB_FIRST=1, DATA_W=8; bits 1,0,1,1,0,1,0,0 on 8 consecutive cycles, dout_ready=1 -> dout=0xB4, dout_valid high exactly 1 cycle, on the cycle after the 8th bit; bit_cnt back to 0.
2. MSB_FIRST=0, same bit sequence, with din_valid low for 3 cycles between bits 4 and 5 -> dout=0x2D; bit_cnt holds at 4 during the gap.
3. dout_ready=0; send 0x11 then 0x22 back-to-back -> dout stays 0x11, overrun=1 after the 16th bit. Assert dout_ready -> one transfer of 0x11, then dout_valid=0. Pulse clr -> overrun=0.
4. Word 0x33 pending; 0x44 completes on the same edge that dout_ready=1 -> 0x33 accepted, dout=0x44 next cycle, dout_valid stays 1, overrun=0.
5. clr asserted after 5 bits of a word, together with din_valid=1 -> bit_cnt=0 and that bit is dropped; the next 8 bits 0xC3 yield dout=0xC3. A pending word present before clr remains valid.
6. rst_n pulled low asynchronously mid-word (between clock edges) with a pending word -> all outputs 0 immediately. After release, a fresh 8-bit 0x5A is received correctly.
